// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: accepts one or two sequential
// instructions per cycle and hands one per cycle to decode with its fetch exception flags.
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_two,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [63:0]              in_instr,
  input  logic [2:0]               in_exc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pcplus4,
  output logic [31:0]              out_instr,
  output logic [2:0]               out_exc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW-1:0] PTR_TWO    = AW'(2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_TWO    = CW'(2);
  localparam logic [CW-1:0] READY_MAX  = CW'(DEPTH - 2);

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [2:0]    exc_mem_q   [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_fire_s;
  logic          pop_fire_s;
  logic          push_two_s;
  logic [CW-1:0] push_n_s;
  logic [AW-1:0] tail_p1_s;

  assign in_ready    = (count_q <= READY_MAX);
  assign out_valid   = (count_q != {CW{1'b0}});
  assign count       = count_q;

  // A faulting fetch group terminates the stream, so only its first word is kept.
  assign push_two_s  = in_two && (in_exc == 3'b000);
  assign push_fire_s = in_valid && in_ready && !flush;
  assign pop_fire_s  = out_valid && out_ready && !flush;
  assign tail_p1_s   = tail_q + PTR_ONE;

  // Next-state for pointers and occupancy; flush discards everything.
  always_comb begin
    push_n_s = {CW{1'b0}};
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (push_fire_s) begin
      push_n_s = push_two_s ? CNT_TWO : CNT_ONE;
      tail_d   = push_two_s ? (tail_q + PTR_TWO) : tail_p1_s;
    end else begin
      push_n_s = {CW{1'b0}};
    end
    if (pop_fire_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end
    count_d = count_q + push_n_s - {{(CW-1){1'b0}}, pop_fire_s};
    if (flush) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left unreset; stale data is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push_fire_s) begin
      pc_mem_q[tail_q]    <= in_pc;
      instr_mem_q[tail_q] <= in_instr[31:0];
      exc_mem_q[tail_q]   <= in_exc;
      if (push_two_s) begin
        pc_mem_q[tail_p1_s]    <= in_pc + 32'd4;
        instr_mem_q[tail_p1_s] <= in_instr[63:32];
        exc_mem_q[tail_p1_s]   <= 3'b000;
      end
    end
  end

  // Head read, zeroed when empty so decode never sees stale words.
  always_comb begin
    out_pc    = 32'd0;
    out_instr = 32'd0;
    out_exc   = 3'b000;
    if (out_valid) begin
      out_pc    = pc_mem_q[head_q];
      out_instr = instr_mem_q[head_q];
      out_exc   = exc_mem_q[head_q];
    end else begin
      out_pc    = 32'd0;
      out_instr = 32'd0;
      out_exc   = 3'b000;
    end
  end

  assign out_pcplus4 = out_pc + 32'd4;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and the decode stage of the MIPS pipeline. It accepts up to two sequential instructions per cycle from the I-cache side and presents one instruction per cycle to decode, together with the fetch-time exception flags. Decode uses these flags to fill the instruction-fetch fields of `decode_data_t` (`exception_instr`, `i_tlb_refill`, `i_tlb_invalid`). A flush input from the redirect/exception logic discards all buffered instructions.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥ 4.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: discard all entries (branch redirect, exception, ERET).
- `in_valid` in 1: fetch offers instructions this cycle.
- `in_two` in 1: fetch offers two instructions (otherwise one).
- `in_ready` out 1: queue can accept a two-instruction push.
- `in_pc` in 32: PC of the first offered instruction; the second instruction is at `in_pc+4`.
- `in_instr` in 64: `[31:0]` holds the first instruction, `[63:32]` the second.
- `in_exc` in 3: `{adel, tlb_refill, tlb_invalid}` for the fetch group.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: decode consumes the head entry.
- `out_pc` out 32: head PC.
- `out_pcplus4` out 32: `out_pc+4`.
- `out_instr` out 32: head instruction word.
- `out_exc` out 3: head exception flags.
- `count` out $clog2(DEPTH)+1: current number of occupied entries.

## Operation
- Storage: circular buffer of `DEPTH` entries, each holding `{pc[31:0], instr[31:0], exc[2:0]}`.
- Pointers: head and tail are $clog2(DEPTH) bits wide and wrap modulo `DEPTH`. Occupancy is tracked in the `count` register.
- Push fires when `in_valid && in_ready && !flush`.
  - Number of entries written: n = 2 if `in_two && in_exc==0`, otherwise 1.
  - A nonzero `in_exc` always pushes only the first instruction. The faulting group terminates the fetch stream.
  - Entry at `tail`: `{in_pc, in_instr[31:0], in_exc}`.
  - If n = 2, entry at `tail+1`: `{in_pc+4, in_instr[63:32], 3'b0}`.
  - `tail` advances by n.
- Pop fires when `out_valid && out_ready && !flush`. `head` advances by 1.
- Count update: `count_next = count + push_n - pop`. Push and pop may fire in the same cycle.
- Flush: at the next edge, `head`, `tail` and `count` all become 0. Flush overrides any push or pop in the same cycle, so nothing is written and nothing is consumed.
- `in_ready` = `(DEPTH - count) >= 2`.
  - It depends on registered state only, not on `out_ready` in the same cycle.
  - When `count == DEPTH-1`, `in_ready` is 0, even for a single-instruction offer.
- `out_valid` = `count != 0`.
- Output data:
  - `out_pc`, `out_instr` and `out_exc` are read from the head entry.
  - All three are forced to 0 when `out_valid == 0`. `out_pcplus4` is then 4.
- Arithmetic: PC addition is 32-bit and wraps modulo 2^32; no carry out is kept.
- Reset state:
  - Reset has priority over flush.
  - Pointers and `count` are 0, so `out_valid` = 0, `in_ready` = 1, `count` = 0.
  - Entry storage is not reset.

## Timing
- Push-to-output latency is one cycle: an entry written at edge N appears on `out_*` after edge N. There is no same-cycle bypass from input to output.
- Pop is acknowledged on the same edge: after the edge, `out_*` shows the next entry, or zeros if the queue is now empty.
- `flush` asserted in cycle N: `out_valid` = 0 and `count` = 0 from cycle N+1. A push offered in cycle N+1 is accepted normally.
- `reset` asserted mid-stream behaves the same as flush and also takes priority over it.
- Throughput: one pop per cycle sustained. Fill rate is up to two entries per cycle until `count` > `DEPTH-2`.

## Test plan
1. Reset held for 2 cycles, then released → `out_valid`=0, `in_ready`=1, `count`=0, `out_pc`=0, `out_pcplus4`=4.
2. Two-instruction push: `in_pc`=0xBFC00000, `in_instr`={0x00000000, 0x24020001}, `out_ready`=0.
   - Next cycle: `count`=2, `out_pc`=0xBFC00000, `out_instr`=0x24020001.
   - Assert `out_ready` for one cycle → `out_pc`=0xBFC00004, `out_instr`=0, `count`=1.
3. Fill with `DEPTH`=8 and `out_ready`=0: four two-instruction pushes.
   - `in_ready` stays 1 through `count`=6; `count`=8 → `in_ready`=0.
   - Separate run: single pushes until `count`=7 → `in_ready`=0. A further offer is not accepted and `count` stays 7.
4. Exception group: `in_two`=1, `in_exc`=3'b010, `in_pc`=0x00400000 → `count` rises by 1 only, and the head shows `out_exc`=3'b010, `out_pc`=0x00400000.
5. Flush collision: with `count`=5, assert `flush`, a two-instruction push and `out_ready` in the same cycle → next cycle `count`=0, `out_valid`=0. The following push of PC 0x80001000 appears at the head.
6. Wrap-around stream: 40 sequential instructions from 0x80000000, with random `in_two`, `in_valid` and `out_ready` → the popped PC sequence is strictly +4 and complete, with no loss or duplication, and `count` never exceeds 8.
